// File: rtl/wb_grf_pkg.sv
// Shared decode constants and helpers for the W stage: opcodes, write-back
// source selection and load-type encoding.
package wb_grf_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_DM  = 2'd1,
    WD_PC8 = 2'd2
  } wd_sel_t;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_t;

  typedef struct packed {
    wd_sel_t  wd_sel;
    ld_type_t ld_type;
  } wb_ctrl_t;

  // Decode only needs opcode and funct; the rest of the word is irrelevant here.
  function automatic wb_ctrl_t wb_decode(input logic [5:0] op, input logic [5:0] fn);
    wb_ctrl_t c;
    c.wd_sel  = WD_ALU;
    c.ld_type = LD_W;
    case (op)
      OP_LW:  begin c.wd_sel = WD_DM; c.ld_type = LD_W;  end
      OP_LB:  begin c.wd_sel = WD_DM; c.ld_type = LD_B;  end
      OP_LBU: begin c.wd_sel = WD_DM; c.ld_type = LD_BU; end
      OP_LH:  begin c.wd_sel = WD_DM; c.ld_type = LD_H;  end
      OP_LHU: begin c.wd_sel = WD_DM; c.ld_type = LD_HU; end
      OP_JAL: c.wd_sel = WD_PC8;
      OP_SPECIAL: if (fn == FN_JALR) c.wd_sel = WD_PC8;
      default: c.wd_sel = WD_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Sub-word load extractor: picks the addressed byte/halfword from an aligned
// data-memory word and sign- or zero-extends it.
module wb_load_ext
  import wb_grf_pkg::*;
(
  input  logic [1:0]  offset,
  input  ld_type_t    ld_type,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  logic [7:0]  lane_byte [4];
  logic [15:0] lane_half [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign lane_byte[gi] = word[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign lane_half[gi] = word[16*gi +: 16];
    end
  endgenerate

  // Halfword lane ignores offset[0]; misaligned halfwords never reach W.
  assign sel_byte = lane_byte[offset];
  assign sel_half = lane_half[offset[1]];

  always_comb begin
    ext = word;
    case (ld_type)
      LD_B:    ext = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   ext = {24'h0, sel_byte};
      LD_H:    ext = {{16{sel_half[15]}}, sel_half};
      LD_HU:   ext = {16'h0, sel_half};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// W stage: write-back value selection, 31-entry register file with
// same-cycle write-through on both read ports, and the debug trace.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_Instr,
  input  logic [31:0] W_PC,
  input  logic [31:0] W_PCplus8,
  input  logic [4:0]  W_A3,
  input  logic [31:0] W_ALUOut,
  input  logic [31:0] W_DMData,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  output logic [31:0] D_RD1,
  output logic [31:0] D_RD2,
  output logic [31:0] W_WD,
  output logic        W_WE,
  output logic [31:0] W_TracePC,
  output logic [4:0]  W_TraceReg,
  output logic [31:0] W_TraceData
);

  wb_ctrl_t    ctrl;
  logic [31:0] load_data;
  logic [31:0] regs [1:NUM_REGS-1];

  assign ctrl = wb_decode(W_Instr[31:26], W_Instr[5:0]);

  wb_load_ext u_load_ext (
    .offset  (W_ALUOut[1:0]),
    .ld_type (ctrl.ld_type),
    .word    (W_DMData),
    .ext     (load_data)
  );

  always_comb begin
    W_WD = W_ALUOut;
    case (ctrl.wd_sel)
      WD_DM:   W_WD = load_data;
      WD_PC8:  W_WD = W_PCplus8;
      default: W_WD = W_ALUOut;
    endcase
  end

  assign W_WE = (W_A3 != 5'd0) && (W_Instr != 32'd0);

  // Async reset takes priority, so a write coinciding with reset is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (W_WE && (W_A3 == 5'(i))) begin
          regs[i] <= W_WD;
        end
      end
    end
  end

  logic [4:0]  rd_addr [2];
  logic [31:0] rd_data [2];

  assign rd_addr[0] = D_A1;
  assign rd_addr[1] = D_A2;
  assign D_RD1      = rd_data[0];
  assign D_RD2      = rd_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [31:0] stored;

      always_comb begin
        stored = 32'd0;
        for (int i = 1; i < NUM_REGS; i++) begin
          if (rd_addr[gi] == 5'(i)) begin
            stored = regs[i];
          end
        end
      end

      // Write-through lets D read a value W is retiring in this very cycle.
      always_comb begin
        rd_data[gi] = stored;
        if (rd_addr[gi] == 5'd0) begin
          rd_data[gi] = 32'd0;
        end else if (W_WE && (rd_addr[gi] == W_A3)) begin
          rd_data[gi] = W_WD;
        end
      end
    end
  endgenerate

  assign W_TracePC   = W_WE ? W_PC : 32'd0;
  assign W_TraceReg  = W_WE ? W_A3 : 5'd0;
  assign W_TraceData = W_WE ? W_WD : 32'd0;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed scenarios followed by random
// instruction traffic checked against an architectural register-file model.
module tb_wb_grf;

  logic        clk;
  logic        reset;
  logic [31:0] W_Instr;
  logic [31:0] W_PC;
  logic [31:0] W_PCplus8;
  logic [4:0]  W_A3;
  logic [31:0] W_ALUOut;
  logic [31:0] W_DMData;
  logic [4:0]  D_A1;
  logic [4:0]  D_A2;
  logic [31:0] D_RD1;
  logic [31:0] D_RD2;
  logic [31:0] W_WD;
  logic        W_WE;
  logic [31:0] W_TracePC;
  logic [4:0]  W_TraceReg;
  logic [31:0] W_TraceData;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] rf_m [32];

  wb_grf #(.RESET_VALUE(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .W_Instr     (W_Instr),
    .W_PC        (W_PC),
    .W_PCplus8   (W_PCplus8),
    .W_A3        (W_A3),
    .W_ALUOut    (W_ALUOut),
    .W_DMData    (W_DMData),
    .D_A1        (D_A1),
    .D_A2        (D_A2),
    .D_RD1       (D_RD1),
    .D_RD2       (D_RD2),
    .W_WD        (W_WD),
    .W_WE        (W_WE),
    .W_TracePC   (W_TracePC),
    .W_TraceReg  (W_TraceReg),
    .W_TraceData (W_TraceData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of the write-back value, computed from the ISA rules.
  function automatic logic [31:0] model_wd(input logic [31:0] instr, input logic [31:0] alu,
                                           input logic [31:0] dm, input logic [31:0] pc8);
    logic [5:0]  op;
    logic [31:0] b;
    logic [31:0] h;
    op = instr[31:26];
    b  = (dm >> (8 * alu[1:0])) & 32'hFF;
    h  = (dm >> (16 * alu[1])) & 32'hFFFF;
    case (op)
      6'h23: return dm;
      6'h20: return b[7] ? (b | 32'hFFFF_FF00) : b;
      6'h24: return b;
      6'h21: return h[15] ? (h | 32'hFFFF_0000) : h;
      6'h25: return h;
      6'h03: return pc8;
      6'h00: return (instr[5:0] == 6'h09) ? pc8 : alu;
      default: return alu;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a, input logic we,
                                           input logic [4:0] a3, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && a == a3) return wd;
    return rf_m[a];
  endfunction

  // One W-stage transaction: drive at negedge, check combinationally, and let
  // the following posedge commit into both DUT and model.
  task automatic apply(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] pc8, input logic [4:0] a3, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] ewd;
    logic        ewe;
    @(negedge clk);
    W_Instr = instr; W_PC = pc; W_PCplus8 = pc8; W_A3 = a3;
    W_ALUOut = alu; W_DMData = dm; D_A1 = a1; D_A2 = a2;
    #1;
    ewd = model_wd(instr, alu, dm, pc8);
    ewe = (a3 != 5'd0) && (instr != 32'd0);
    chk({tag, ".we"}, {31'd0, W_WE}, {31'd0, ewe});
    chk({tag, ".wd"}, W_WD, ewd);
    chk({tag, ".rd1"}, D_RD1, model_rd(a1, ewe, a3, ewd));
    chk({tag, ".rd2"}, D_RD2, model_rd(a2, ewe, a3, ewd));
    chk({tag, ".tpc"}, W_TracePC, ewe ? pc : 32'd0);
    chk({tag, ".treg"}, {27'd0, W_TraceReg}, ewe ? {27'd0, a3} : 32'd0);
    chk({tag, ".tdata"}, W_TraceData, ewe ? ewd : 32'd0);
    $display("[TB] %s instr=%h a3=%0d wd=%h we=%b rd1=%h rd2=%h", tag, instr, a3, W_WD, W_WE, D_RD1, D_RD2);
    if (ewe) rf_m[a3] = ewd;
  endtask

  localparam logic [31:0] ADDU_8 = {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h21};

  initial begin
    logic [31:0] instr;
    logic [4:0]  a3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    int          kind;

    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    reset = 1'b0;
    W_Instr = 32'd0; W_PC = 32'd0; W_PCplus8 = 32'd0; W_A3 = 5'd0;
    W_ALUOut = 32'd0; W_DMData = 32'd0; D_A1 = 5'd5; D_A2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.we", {31'd0, W_WE}, 32'd0);
    chk("rst.tpc", W_TracePC, 32'd0);
    chk("rst.rd1", D_RD1, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    apply("rel", 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    apply("addu", ADDU_8, 32'h0000_1000, 32'h0000_1008, 5'd8, 32'hDEAD_BEEF, 32'd0, 5'd8, 5'd8);
    apply("bub8", 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd8, 5'd0);
    chk("bub8.hold", D_RD1, 32'hDEAD_BEEF);

    apply("lb",  {6'h20, 26'h0}, 32'h2000, 32'h2008, 5'd9,  32'h0000_1002, 32'h8081_7F02, 5'd9,  5'd0);
    chk("lb.val", W_WD, 32'hFFFF_FF81);
    apply("lbu", {6'h24, 26'h0}, 32'h2004, 32'h200C, 5'd10, 32'h0000_1002, 32'h8081_7F02, 5'd9,  5'd10);
    chk("lbu.val", W_WD, 32'h0000_0081);
    apply("lh",  {6'h21, 26'h0}, 32'h2008, 32'h2010, 5'd11, 32'h0000_1002, 32'h8081_7F02, 5'd10, 5'd11);
    chk("lh.val", W_WD, 32'hFFFF_8081);
    apply("lhu", {6'h25, 26'h0}, 32'h200C, 32'h2014, 5'd12, 32'h0000_1002, 32'h8081_7F02, 5'd11, 5'd12);
    chk("lhu.val", W_WD, 32'h0000_8081);
    apply("lw",  {6'h23, 26'h0}, 32'h2010, 32'h2018, 5'd13, 32'h0000_1002, 32'h8081_7F02, 5'd13, 5'd12);
    chk("lw.val", W_WD, 32'h8081_7F02);

    apply("jal", {6'h03, 26'h0000C00}, 32'h0000_3000, 32'h0000_3008, 5'd31, 32'h1111_1111, 32'd0, 5'd31, 5'd31);
    chk("jal.treg", {27'd0, W_TraceReg}, 32'd31);
    chk("jal.tdata", W_TraceData, 32'h0000_3008);
    apply("jalchk", 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd31, 5'd8);
    chk("jal.stored", D_RD1, 32'h0000_3008);

    apply("zero", ADDU_8, 32'h4000, 32'h4008, 5'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0);
    chk("zero.we", {31'd0, W_WE}, 32'd0);
    chk("zero.rd1", D_RD1, 32'd0);

    apply("set4", ADDU_8, 32'h4100, 32'h4108, 5'd4, 32'h0000_0055, 32'd0, 5'd0, 5'd0);
    apply("bub4", 32'd0, 32'h4104, 32'h410C, 5'd4, 32'h0000_0007, 32'd0, 5'd4, 5'd4);
    apply("bub4b", 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd4, 5'd0);
    chk("bub4.keep", D_RD1, 32'h0000_0055);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: instr = {6'h00, 20'($urandom), 6'h21};
        1: instr = {6'h0D, 26'($urandom)};
        2: instr = {6'h23, 26'($urandom)};
        3: instr = {6'h20, 26'($urandom)};
        4: instr = {6'h24, 26'($urandom)};
        5: instr = {6'h21, 26'($urandom)};
        6: instr = {6'h25, 26'($urandom)};
        7: instr = {6'h03, 26'($urandom)};
        8: instr = {6'h00, 20'($urandom), 6'h09};
        default: instr = 32'd0;
      endcase
      a3 = 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom);
      apply("rnd", instr, $urandom, $urandom, a3, $urandom, $urandom, a1, a2);
    end

    apply("w5", ADDU_8, 32'h5000, 32'h5008, 5'd5, 32'h1234_5678, 32'd0, 5'd5, 5'd0);
    @(negedge clk);
    W_Instr = 32'd0; W_A3 = 5'd0; D_A1 = 5'd5; D_A2 = 5'd5;
    #1;
    chk("w5.stored", D_RD1, 32'h1234_5678);
    reset = 1'b0;
    #1;
    chk("arst.rd1", D_RD1, 32'd0);
    chk("arst.rd2", D_RD2, 32'd0);
    $display("[TB] async reset asserted mid-cycle rd1=%h", D_RD1);
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    apply("post", 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd8, 5'd31);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back stage and general register file of the five-stage MIPS pipeline. Takes the W-stage bundle from the M/W pipeline register and selects the write-back value: ALU result, load data, or link address. Sign- or zero-extends sub-word loads, then writes the 31-entry register file. Serves the two D-stage read ports with same-cycle write-through bypass, and drives the debug write-back trace.

## Interface
Parameters:
- RESET_VALUE, 32'h0000_0000, value every register takes on reset

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- W_Instr  in  32  instruction in W; 32'b0 = bubble
- W_PC  in  32  PC of W instruction (trace only)
- W_PCplus8  in  32  link address for jal/jalr
- W_A3  in  5  destination register number
- W_ALUOut  in  32  ALU/MDU/CP0 result; bits [1:0] = load byte offset
- W_DMData  in  32  raw aligned data-memory word
- D_A1  in  5  read port 1 address (rs)
- D_A2  in  5  read port 2 address (rt)
- D_RD1  out  32  read data 1
- D_RD2  out  32  read data 2
- W_WD  out  32  selected write-back value, also used as the forwarding source for E/D
- W_WE  out  1  register write strobe for the current cycle
- W_TracePC  out  32  debug: PC of retiring write
- W_TraceReg  out  5  debug: register written
- W_TraceData  out  32  debug: value written

## Operation
- Opcode is W_Instr[31:26]; funct is W_Instr[5:0].
- Write-back select:
  - lw (0x23), lb (0x20), lbu (0x24), lh (0x21) or lhu (0x25): W_WD = extended load.
  - jal (0x03), or jalr (opcode 0, funct 0x09): W_WD = W_PCplus8.
  - Otherwise: W_WD = W_ALUOut.
- Load extension, with offset = W_ALUOut[1:0]:
  - lb/lbu select byte W_DMData[8*offset+7 : 8*offset].
  - lh/lhu select the halfword at W_ALUOut[1]; bit 0 is ignored because misaligned accesses are trapped upstream.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Write enable: W_WE = (W_A3 != 0) && (W_Instr != 0).
- Register 0 is not stored and always reads 0.
- Register array is 31 x 32 bits (indices 1..31).
- Read ports are combinational:
  - Dn_RD = 0 if Dn_A == 0.
  - Dn_RD = W_WD if W_WE && Dn_A == W_A3.
  - Otherwise Dn_RD = the stored register.
- Trace outputs equal W_PC / W_A3 / W_WD when W_WE = 1. They are all zeros when W_WE = 0.

## Timing
- Reset low, at any time and asynchronously: all 31 registers become RESET_VALUE immediately. Writes are blocked while reset is low. Read ports then return RESET_VALUE, or 0 for index 0.
- Outputs are combinational from the stage inputs. Their values under reset follow the inputs; the M/W register delivers a bubble, so W_WE = 0 and all trace outputs are 0.
- A write commits on the rising clk edge while W_WE = 1 and reset is high. It is visible in the array from the next cycle, and via bypass in the same cycle.
- Zero latency from the stage inputs to W_WD, D_RD1/2 and the trace outputs.
- Reset deasserting on the same edge as a valid write: the write is discarded. Reset must be high before the edge.
- D_A1 == D_A2 == W_A3 is legal: both ports bypass.
- The block has no stall or enable, because the W stage never stalls. The M/W register holds W_Instr = 0 to idle the block.

## Structure
- Shared package/header: opcode and funct constants (OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_JAL, FN_JALR), the write-back select encoding (WD_ALU, WD_DM, WD_PC8) and load-type encoding.
- One sub-module: wb_load_ext, a combinational byte/halfword extractor and extender (inputs: offset, load type, raw word).
- The regfile array and bypass live in the top module.

## Test plan
- Reset: hold reset = 0, then release. Then D_A1 = 5, D_A2 = 0 → both reads return 0. Asserting reset mid-run after writing $5 = 32'h1234_5678 → $5 reads 0 immediately, without a clock edge.
- ALU write + bypass: W_Instr = addu, W_A3 = 8, W_ALUOut = 32'hDEAD_BEEF, D_A1 = 8 → D_RD1 = 32'hDEAD_BEEF the same cycle. After the edge with a bubble in W, D_RD1 still = 32'hDEAD_BEEF.
- Loads: W_DMData = 32'h8081_7F02, W_ALUOut[1:0] = 2'b10:
  - lb → 32'hFFFF_FF81.
  - lbu → 32'h0000_0081.
  - lh → 32'hFFFF_8081.
  - lhu → 32'h0000_8081.
  - lw → 32'h8081_7F02.
- Link: jal with W_PCplus8 = 32'h0000_3008, W_A3 = 31 → $31 = 32'h0000_3008. Trace shows PC/31/3008.
- $0 protection: W_A3 = 0, W_ALUOut = 32'hFFFF_FFFF, W_Instr nonzero → W_WE = 0, D_RD1 (A1 = 0) = 0, trace outputs = 0.
- Bubble: W_Instr = 0, W_A3 = 4, W_ALUOut = 7 → no write; $4 keeps its previous value.
